// File: rtl/mux_2x1_lanes_if.sv
// Lane input / muxed output bundle for mux_2x1_lanes.
// master = traffic source/sink, slave = the mux itself.
interface mux_2x1_lanes_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in_0;
  logic              valid_in_0;
  logic [DATA_W-1:0] data_in_1;
  logic              valid_in_1;
  logic              ready_0;
  logic              ready_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              lane_out;
  logic              overflow_0;
  logic              overflow_1;

  modport master (
    output data_in_0, valid_in_0,
    output data_in_1, valid_in_1,
    input  ready_0, ready_1,
    input  data_out, valid_out, lane_out,
    input  overflow_0, overflow_1
  );

  modport slave (
    input  data_in_0, valid_in_0,
    input  data_in_1, valid_in_1,
    output ready_0, ready_1,
    output data_out, valid_out, lane_out,
    output overflow_0, overflow_1
  );
endinterface

// File: rtl/mux_2x1_lanes.sv
// Two-lane to one-lane round-robin interleaver with per-lane FIFOs.
// Optional MUX2_DROP_COUNT_EN adds a saturating drop_count output.
module mux_2x1_lanes #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_2f,
  input  logic reset,
`ifdef MUX2_DROP_COUNT_EN
  output logic [7:0] drop_count,
`endif
  mux_2x1_lanes_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SERVE0 = 2'd1;
  localparam logic [1:0] S_SERVE1 = 2'd2;

  logic [DATA_W-1:0] mem0 [FIFO_DEPTH];
  logic [DATA_W-1:0] mem1 [FIFO_DEPTH];
  logic [AW-1:0]     wr0, rd0, wr1, rd1;
  logic [AW:0]       cnt0, cnt1;
  logic              prio;
  logic [1:0]        st, st_nxt;
  logic              push0, push1;
  logic              drop0, drop1;
  logic              ne0, ne1;
  logic              serve0, serve1;

  assign ne0    = (cnt0 != '0);
  assign ne1    = (cnt1 != '0);
  assign push0  = bus.valid_in_0 && (cnt0 != FULL);
  assign push1  = bus.valid_in_1 && (cnt1 != FULL);
  assign drop0  = bus.valid_in_0 && (cnt0 == FULL);
  assign drop1  = bus.valid_in_1 && (cnt1 == FULL);
  assign serve0 = ne0 && (!ne1 || !prio);
  assign serve1 = ne1 && (!ne0 || prio);

  assign bus.ready_0   = (cnt0 != FULL);
  assign bus.ready_1   = (cnt1 != FULL);
  assign bus.valid_out = (st != S_IDLE);

  // Pick the next output state from the pre-edge arbitration result
  always_comb begin
    st_nxt = S_IDLE;
    unique case (1'b1)
      serve0:  st_nxt = S_SERVE0;
      serve1:  st_nxt = S_SERVE1;
      default: st_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset, pointers gate visibility
  always_ff @(posedge clk_2f) begin
    if (push0) mem0[wr0] <= bus.data_in_0;
    if (push1) mem1[wr1] <= bus.data_in_1;
  end

  // Lane 0 pointers and occupancy
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      wr0  <= '0;
      rd0  <= '0;
      cnt0 <= '0;
    end else begin
      if (push0) wr0 <= wr0 + 1'b1;
      if (serve0) rd0 <= rd0 + 1'b1;
      if (push0 && !serve0) cnt0 <= cnt0 + 1'b1;
      else if (!push0 && serve0) cnt0 <= cnt0 - 1'b1;
    end
  end

  // Lane 1 pointers and occupancy
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      wr1  <= '0;
      rd1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push1) wr1 <= wr1 + 1'b1;
      if (serve1) rd1 <= rd1 + 1'b1;
      if (push1 && !serve1) cnt1 <= cnt1 + 1'b1;
      else if (!push1 && serve1) cnt1 <= cnt1 - 1'b1;
    end
  end

  // Output register, round-robin priority and sticky overflow flags
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      st             <= S_IDLE;
      prio           <= 1'b0;
      bus.data_out   <= '0;
      bus.lane_out   <= 1'b0;
      bus.overflow_0 <= 1'b0;
      bus.overflow_1 <= 1'b0;
    end else begin
      st <= st_nxt;
      if (serve0) begin
        bus.data_out <= mem0[rd0];
        bus.lane_out <= 1'b0;
        prio         <= 1'b1;
      end else if (serve1) begin
        bus.data_out <= mem1[rd1];
        bus.lane_out <= 1'b1;
        prio         <= 1'b0;
      end else begin
        bus.data_out <= '0;
      end
      if (drop0) bus.overflow_0 <= 1'b1;
      if (drop1) bus.overflow_1 <= 1'b1;
    end
  end

`ifdef MUX2_DROP_COUNT_EN
  logic [8:0] dc_sum;
  assign dc_sum = {1'b0, drop_count}
                + {8'd0, drop0} + {8'd0, drop1};

  // Saturating count of dropped words
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) drop_count <= 8'd0;
    else if (dc_sum[8]) drop_count <= 8'hFF;
    else drop_count <= dc_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_mux_2x1_lanes.sv
// Randomized and directed bench for mux_2x1_lanes.
// Reference model: per-lane queues with round-robin service.
module tb_mux_2x1_lanes;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic clk_2f;
  logic reset;
`ifdef MUX2_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  mux_2x1_lanes_if #(.DATA_W(DW)) bus ();

  mux_2x1_lanes #(
    .DATA_W(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_2f(clk_2f),
    .reset(reset),
`ifdef MUX2_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .bus(bus)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  int n_tests = 0;
  int n_fail = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            m_prio;
  logic [DW-1:0] e_data;
  bit            e_valid;
  bit            e_lane;
  bit            e_ovf0, e_ovf1;
  int            e_drops;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".data"}, 32'(bus.data_out), 32'(e_data));
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(e_valid));
    chk({tag, ".lane"}, 32'(bus.lane_out), 32'(e_lane));
    chk({tag, ".ovf0"}, 32'(bus.overflow_0), 32'(e_ovf0));
    chk({tag, ".ovf1"}, 32'(bus.overflow_1), 32'(e_ovf1));
`ifdef MUX2_DROP_COUNT_EN
    chk({tag, ".drops"}, 32'(drop_count),
        32'((e_drops > 255) ? 255 : e_drops));
`endif
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_prio  = 1'b0;
    e_data  = '0;
    e_valid = 1'b0;
    e_lane  = 1'b0;
    e_ovf0  = 1'b0;
    e_ovf1  = 1'b0;
    e_drops = 0;
  endtask

  // One clock: drive, check ready, advance model, check outputs
  task automatic cycle(input string tag,
                       input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1);
    int n0, n1;
    bus.valid_in_0 = v0;
    bus.data_in_0  = d0;
    bus.valid_in_1 = v1;
    bus.data_in_1  = d1;
    #1;
    n0 = q0.size();
    n1 = q1.size();
    chk({tag, ".rdy0"}, 32'(bus.ready_0), 32'(n0 < DEPTH));
    chk({tag, ".rdy1"}, 32'(bus.ready_1), 32'(n1 < DEPTH));
    if (n0 > 0 && (n1 == 0 || m_prio == 1'b0)) begin
      e_data  = q0.pop_front();
      e_valid = 1'b1;
      e_lane  = 1'b0;
      m_prio  = 1'b1;
    end else if (n1 > 0) begin
      e_data  = q1.pop_front();
      e_valid = 1'b1;
      e_lane  = 1'b1;
      m_prio  = 1'b0;
    end else begin
      e_data  = '0;
      e_valid = 1'b0;
    end
    if (v0) begin
      if (n0 >= DEPTH) begin
        e_ovf0 = 1'b1;
        e_drops++;
      end else q0.push_back(d0);
    end
    if (v1) begin
      if (n1 >= DEPTH) begin
        e_ovf1 = 1'b1;
        e_drops++;
      end else q1.push_back(d1);
    end
    @(posedge clk_2f);
    #1;
    chk_outs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, '0, 0, '0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_clear();
    chk_outs({tag, ".async"});
    chk({tag, ".rdy0"}, 32'(bus.ready_0), 32'd1);
    chk({tag, ".rdy1"}, 32'(bus.ready_1), 32'd1);
    @(posedge clk_2f);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.valid_in_0 = 1'b0;
    bus.valid_in_1 = 1'b0;
    bus.data_in_0  = '0;
    bus.data_in_1  = '0;
    model_clear();
    @(posedge clk_2f);
    #1;
    do_reset("rst0");

    cycle("a5", 1, 8'hA5, 0, '0);
    cycle("a5", 0, '0, 0, '0);
    chk("a5.direct", 32'(bus.data_out), 32'hA5);
    cycle("a5", 0, '0, 0, '0);
    chk("a5.idle", 32'(bus.valid_out), 32'd0);

    cycle("pair", 1, 8'h11, 1, 8'h22);
    idle("pair", 3);

    for (int i = 1; i <= 3; i++) begin
      cycle("alt0", 1, 8'(i), 0, '0);
      cycle("alt0", 0, '0, 0, '0);
    end
    cycle("prio", 1, 8'h44, 1, 8'h55);
    idle("prio", 3);

    for (int i = 0; i < 8; i++)
      cycle("l1", 0, '0, 1, 8'h30 + 8'(i));
    idle("l1", 2);

    for (int i = 0; i < 12; i++)
      cycle("both", 1, 8'(8'h60 + i), 1, 8'(8'h80 + i));
    idle("both", 10);

    do_reset("rst1");
    for (int i = 0; i < 4; i++)
      cycle("fill", 1, 8'(8'hC0 + i), 1, 8'(8'hD0 + i));
    do_reset("rst2");
    idle("stale", 4);

    for (int seg = 0; seg < 6; seg++) begin
      int duty;
      duty = 20 + seg * 16;
      for (int i = 0; i < 300; i++) begin
        bit v0, v1;
        v0 = ($urandom_range(99) < duty);
        v1 = ($urandom_range(99) < duty);
        cycle("rand", v0, 8'($urandom),
              v1, 8'($urandom));
      end
      if (seg == 2) do_reset("rst3");
    end
    idle("drain", 10);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
